// File: rtl/reversible_restoring_divider.sv
// ---------------------------------------------------------------------------
// reversible_restoring_divider
//   Sequential unsigned restoring divider, one quotient bit per RUN cycle.
//   The trial subtraction R - D is formed as R + ~D + 1 on a chain of
//   reversible (Peres-gate) full adders: WIDTH/4 four-bit slices plus one
//   extra full adder for the top bit, carry-in tied to 1.
//
//   Optional feature macro: DIV_ZERO_FLAG_EN
//     defined   -> div_zero port present; divisor 0 finishes in one edge
//     undefined -> no div_zero port; divisor 0 runs the full algorithm
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request, sampled only in IDLE
//   dividend   in   WIDTH  unsigned dividend, sampled with start
//   divisor    in   WIDTH  unsigned divisor, sampled with start
//   busy       out  high while a division is running
//   done       out  one-cycle pulse, quotient/remainder valid
//   quotient   out  WIDTH  unsigned quotient
//   remainder  out  WIDTH  unsigned remainder
//   div_zero   out  divide-by-zero flag (DIV_ZERO_FLAG_EN only)
// ---------------------------------------------------------------------------

// Reversible full adder built from two Peres gates.
//   Peres(A,B,C) = (A, A^B, (A&B)^C)
//   gate 1: (a, b, 0)    -> (a, p=a^b, g=a&b)
//   gate 2: (p, cin, g)  -> (p, sum=p^cin, cout=(p&cin)^g)
module rev_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p;
  logic g;

  assign p    = a ^ b;
  assign g    = a & b;
  assign sum  = p ^ cin;
  assign cout = (p & cin) ^ g;
endmodule

// Four-bit ripple slice of reversible full adders.
module rev_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    rev_fa u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end
  assign cout = c[4];
endmodule

module reversible_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
`ifdef DIV_ZERO_FLAG_EN
  output logic             div_zero,
`endif
  output logic [WIDTH-1:0] remainder
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = $clog2(WIDTH + 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("reversible_restoring_divider: WIDTH must be a positive multiple of 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;       // partial remainder, always < D between iterations
  logic [WIDTH-1:0] q_q, q_d;       // dividend bits shifting out / quotient bits shifting in
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             accept;
  logic             finish;
`ifdef DIV_ZERO_FLAG_EN
  logic             dz_q, dz_d;     // latched "divisor was zero" for the current job
  logic             dzf_q, dzf_d;   // flag presented alongside the result
`endif

  // Trial subtraction operands: {R,Q} shifted left by one, minus {0,D}.
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   d_inv;
  logic [WIDTH-1:0] t_low;
  logic             t_sign;
  logic             t_cout;
  logic [NSLICE:0]  sc;
  logic             no_borrow;

  assign r_sh  = {r_q, q_q[WIDTH-1]};
  assign d_inv = ~{1'b0, d_q};
  assign sc[0] = 1'b1;

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    rev_add4 u_slice (
      .a   (r_sh[4*s +: 4]),
      .b   (d_inv[4*s +: 4]),
      .cin (sc[s]),
      .sum (t_low[4*s +: 4]),
      .cout(sc[s+1])
    );
  end

  rev_fa u_top (
    .a   (r_sh[WIDTH]),
    .b   (d_inv[WIDTH]),
    .cin (sc[NSLICE]),
    .sum (t_sign),
    .cout(t_cout)
  );

  // Carry-out 1 means R >= D. The sign bit is then 0 as well, because the
  // shifted remainder is below 2*D; requiring both keeps a malformed trial
  // from ever being committed.
  assign no_borrow = t_cout & ~t_sign;

  assign accept = (state_q == S_IDLE) && start;
`ifdef DIV_ZERO_FLAG_EN
  assign finish = (state_q == S_RUN) && ((cnt_q == '0) || dz_q);
`else
  assign finish = (state_q == S_RUN) && (cnt_q == '0);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (finish) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero  = dzf_q;
`endif

  // Datapath next-state
  always_comb begin
    cnt_d  = cnt_q;
    r_d    = r_q;
    q_d    = q_q;
    d_d    = d_q;
    quot_d = quot_q;
    rem_d  = rem_q;
`ifdef DIV_ZERO_FLAG_EN
    dz_d   = dz_q;
    dzf_d  = dzf_q;
`endif
    if (accept) begin
      d_d   = divisor;
      q_d   = dividend;
      r_d   = '0;
      cnt_d = CW'(WIDTH);
`ifdef DIV_ZERO_FLAG_EN
      dz_d  = (divisor == '0);
      dzf_d = 1'b0;
`endif
    end else if (finish) begin
`ifdef DIV_ZERO_FLAG_EN
      if (dz_q) begin
        // Q still holds the unshifted dividend when RUN is skipped.
        quot_d = '1;
        rem_d  = q_q;
        dzf_d  = 1'b1;
      end else begin
        quot_d = q_q;
        rem_d  = r_q;
      end
`else
      quot_d = q_q;
      rem_d  = r_q;
`endif
    end else if (state_q == S_RUN) begin
      if (no_borrow) begin
        r_d = t_low;
        q_d = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        r_d = r_sh[WIDTH-1:0];  // restore: keep the shifted remainder
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q   <= 1'b0;
      dzf_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      r_q    <= r_d;
      q_q    <= q_d;
      d_q    <= d_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
`ifdef DIV_ZERO_FLAG_EN
      dz_q   <= dz_d;
      dzf_q  <= dzf_d;
`endif
    end
  end

endmodule

// File: tb/tb_reversible_restoring_divider.sv
module tb_reversible_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic       div_zero;
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 9;
`endif

  int tests;
  int fails;

  reversible_restoring_divider #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
`ifdef DIV_ZERO_FLAG_EN
    .div_zero (div_zero),
`endif
    .remainder(remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge. Start is accepted on the next edge
  // (edge 0); lat is the number of edges after that until done is seen.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int lat,
                         input logic [7:0] qe, input logic [7:0] re, input string tag);
    int  n;
    int  busy_bad;
    logic seen;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~a; divisor = ~b;  // must be ignored from here on
    n = 0; busy_bad = 0; seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busy_bad++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " busy gaps"}, busy_bad, 0);
    check({tag, " busy at done"}, busy, 1'b0);
    check({tag, " quotient"}, quotient, qe);
    check({tag, " remainder"}, remainder, re);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, done, 1'b0);
    check({tag, " quotient hold"}, quotient, qe);
  endtask

  initial begin
    int n;
    int cnt;
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset quotient", quotient, 8'd0);
    check("reset remainder", remainder, 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Idle for 20 cycles: no done may appear.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    check("idle activity", cnt, 0);

    run_div(8'd200, 8'd7,   9, 8'd28,  8'd4,  "200/7");
    run_div(8'd255, 8'd1,   9, 8'd255, 8'd0,  "255/1");
    run_div(8'd5,   8'd9,   9, 8'd0,   8'd5,  "5/9");
    run_div(8'd0,   8'd3,   9, 8'd0,   8'd0,  "0/3");
    run_div(8'd255, 8'd255, 9, 8'd1,   8'd0,  "255/255");

    // Start pulse while busy must be ignored.
    start = 1'b1; dividend = 8'd50; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; dividend = 8'd100; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n = 4;
    while (done !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy-start latency", n, 9);
    check("busy-start quotient", quotient, 8'd7);
    check("busy-start remainder", remainder, 8'd1);
    @(posedge clk); #1;
    check("busy-start done drop", done, 1'b0);
    // Back-to-back: accepted on edge WIDTH+3 of the previous job.
    run_div(8'd100, 8'd3, 9, 8'd33, 8'd1, "100/3");

    // Asynchronous reset during iteration 4 of 200/7.
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst busy", busy, 1'b0);
    check("async rst done", done, 1'b0);
    check("async rst quotient", quotient, 8'd0);
    check("async rst remainder", remainder, 8'd0);
    #2;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    check("aborted done", cnt, 0);
    run_div(8'd9, 8'd2, 9, 8'd4, 8'd1, "9/2");

    // Divide by zero.
    run_div(8'd77, 8'd0, DZ_LAT, 8'd255, 8'd77, "77/0");
`ifdef DIV_ZERO_FLAG_EN
    check("div_zero held", div_zero, 1'b1);
    start = 1'b1; dividend = 8'd20; divisor = 8'd6;
    @(posedge clk); #1;
    start = 1'b0;
    check("div_zero cleared", div_zero, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("20/6 quotient", quotient, 8'd3);
    check("20/6 remainder", remainder, 8'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
